// File: rtl/imem_bootload.sv
// Instruction memory with synchronous read and a valid/ready boot-load port.
// Fetches return NOP_WORD while loading or when the address is misaligned/out of range.
module imem_bootload #(
   parameter int unsigned ADDR_WIDTH    = 6,
   parameter string       INIT_FILE     = "",
   parameter bit          LOAD_ON_RESET = 1'b0,
   parameter logic [31:0] NOP_WORD      = 32'h00000013
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_en,
   input  logic [31:0]           a,
   output logic [31:0]           rd,
   output logic                  misaligned,
   output logic                  out_of_range,
   input  logic                  prog_start,
   input  logic                  prog_valid,
   output logic                  prog_ready,
   input  logic [31:0]           prog_data,
   input  logic                  prog_last,
   output logic                  cpu_hold,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [0:0] {StLoad, StRun} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [31:0]           mem [DEPTH];

   logic                  accept;
   logic                  final_word;
   logic                  fault_mis;
   logic                  fault_oor;
   logic [ADDR_WIDTH-1:0] raddr;

   assign prog_ready   = (state_q == StLoad);
   assign cpu_hold     = (state_q == StLoad);
   assign words_loaded = cnt_q;

   assign accept     = (state_q == StLoad) & prog_valid;
   // The top word ends the load on its own so wptr never has to wrap.
   assign final_word = accept & (prog_last | (&wptr_q));

   assign fault_mis = |a[1:0];
   assign fault_oor = |(a >> (ADDR_WIDTH + 2));
   assign raddr     = a[ADDR_WIDTH+1:2];

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StRun: begin
            if (prog_start) begin
               state_d = StLoad;
               wptr_d  = '0;
               cnt_d   = '0;
            end
         end
         StLoad: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (!(&wptr_q)) wptr_d = wptr_q + 1'b1;
               if (final_word) state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD_ON_RESET ? StLoad : StRun;
         wptr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Array has no reset; an aborted load keeps whatever was already written.
   always_ff @(posedge clk) begin
      if (accept) mem[wptr_q] <= prog_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd           <= NOP_WORD;
         misaligned   <= 1'b0;
         out_of_range <= 1'b0;
      end else if (fetch_en) begin
         misaligned   <= fault_mis;
         out_of_range <= fault_oor;
         if ((state_q == StRun) && !fault_mis && !fault_oor) rd <= mem[raddr];
         else rd <= NOP_WORD;
      end
   end

endmodule
